// File: rtl/uart_tx_readback.sv
// -----------------------------------------------------------------------------
// uart_tx_readback
//
// Reads a contiguous block of configuration RAM bytes and sends each one as an
// 8N1 frame on Tx so the host can confirm the settings it wrote. The RAM holds
// bytes bit-reversed (as the receiver stored them). Sending shift_q[7] first
// puts the host's original LSB on the wire first, so the host reads back the
// byte it originally sent.
//
// Optional feature (macro READBACK_CSUM_EN):
//   When defined, an 8-bit XOR checksum of the host-form data bytes is sent as
//   one extra frame after the last data byte. It is not sent for len = 0.
//
// Parameters:
//   CLKS_PER_BIT  clock cycles per UART bit (must be >= 4)
//   ADDR_W        RAM address width
//
// Ports:
//   clk_Tx     in   system clock, all logic on posedge
//   rst_Tx     in   synchronous active-high reset
//   start      in   one-cycle request to begin a readback block
//   base_addr  in   first RAM address, sampled when start is accepted
//   len        in   byte count, sampled when start is accepted (0 = none)
//   ram_addr   out  RAM read address (holds last value when idle)
//   ram_re     out  RAM read strobe; ram_data valid one cycle later
//   ram_data   in   RAM read data (bit-reversed byte)
//   Tx         out  registered serial line, idles high
//   busy       out  high while a block is in progress
//   done       out  one-cycle pulse when the block completes
// -----------------------------------------------------------------------------
module uart_tx_readback #(
    parameter int CLKS_PER_BIT = 434,
    parameter int ADDR_W       = 8
) (
    input  logic              clk_Tx,
    input  logic              rst_Tx,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [7:0]        len,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_re,
    input  logic [7:0]        ram_data,
    output logic              Tx,
    output logic              busy,
    output logic              done
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_FETCH = 4'd1,
        S_WAIT  = 4'd2,
        S_START = 4'd3,
        S_DATA  = 4'd4,
        S_STOP  = 4'd5,
        S_NEXT  = 4'd6,
        S_FIN   = 4'd7
`ifdef READBACK_CSUM_EN
        ,
        S_CSUM  = 4'd8
`endif
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_addr_q;
    logic [7:0]        r_rem_q;
    logic [7:0]        r_shift_q;
    logic [CNT_W-1:0]  r_baud;
    logic [2:0]        r_bit_idx;
    logic              r_tx;
    logic              r_busy;
    logic              r_done;
    logic              r_ram_re;
    logic [ADDR_W-1:0] r_ram_addr;
    logic              w_csum_tail;

`ifdef READBACK_CSUM_EN
    logic [7:0] r_csum;
    logic       r_csum_frame;

    // Convert between RAM (reversed) form and host form of a byte.
    function automatic logic [7:0] bit_rev8(input logic [7:0] b);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) begin
            r[i] = b[7-i];
        end
        return r;
    endfunction

    // Marks that the frame just sent was the checksum, so NEXT ends the block.
    assign w_csum_tail = r_csum_frame;
`else
    assign w_csum_tail = 1'b0;
`endif

    // Readback sequencer: RAM fetch, 8N1 serialiser, block bookkeeping.
    always_ff @(posedge clk_Tx) begin
        if (rst_Tx) begin
            r_state    <= S_IDLE;
            r_addr_q   <= {ADDR_W{1'b0}};
            r_rem_q    <= 8'd0;
            r_shift_q  <= 8'd0;
            r_baud     <= CNT_ZERO;
            r_bit_idx  <= 3'd0;
            r_tx       <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_ram_re   <= 1'b0;
            r_ram_addr <= {ADDR_W{1'b0}};
`ifdef READBACK_CSUM_EN
            r_csum       <= 8'd0;
            r_csum_frame <= 1'b0;
`endif
        end else begin
            // Strobes are single-cycle unless a state re-asserts them.
            r_done   <= 1'b0;
            r_ram_re <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_addr_q <= base_addr;
                        r_rem_q  <= len;
`ifdef READBACK_CSUM_EN
                        r_csum       <= 8'd0;
                        r_csum_frame <= 1'b0;
`endif
                        if (len == 8'd0) begin
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= S_FIN;
                        end else begin
                            // Issue the read now so the strobe is visible in FETCH.
                            r_busy     <= 1'b1;
                            r_ram_addr <= base_addr;
                            r_ram_re   <= 1'b1;
                            r_state    <= S_FETCH;
                        end
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_FETCH: begin
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    // Read data arrives now; capture it and drop into the start bit.
                    r_shift_q <= ram_data;
`ifdef READBACK_CSUM_EN
                    r_csum <= r_csum ^ bit_rev8(ram_data);
`endif
                    r_tx    <= 1'b0;
                    r_baud  <= CNT_ZERO;
                    r_state <= S_START;
                end
                S_START: begin
                    if (r_baud == BAUD_LAST) begin
                        r_baud    <= CNT_ZERO;
                        r_bit_idx <= 3'd0;
                        r_tx      <= r_shift_q[7];
                        r_state   <= S_DATA;
                    end else begin
                        r_baud <= r_baud + CNT_ONE;
                    end
                end
                S_DATA: begin
                    if (r_baud == BAUD_LAST) begin
                        r_baud <= CNT_ZERO;
                        if (r_bit_idx == 3'd7) begin
                            r_tx    <= 1'b1;
                            r_state <= S_STOP;
                        end else begin
                            // MSB-first shift of the reversed byte = host LSB first.
                            r_bit_idx <= r_bit_idx + 3'd1;
                            r_tx      <= r_shift_q[6];
                            r_shift_q <= {r_shift_q[6:0], 1'b0};
                        end
                    end else begin
                        r_baud <= r_baud + CNT_ONE;
                    end
                end
                S_STOP: begin
                    if (r_baud == BAUD_LAST) begin
                        r_baud  <= CNT_ZERO;
                        r_state <= S_NEXT;
                    end else begin
                        r_baud <= r_baud + CNT_ONE;
                    end
                end
                S_NEXT: begin
                    if (w_csum_tail) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_FIN;
                    end else if (r_rem_q == 8'd1) begin
                        r_rem_q  <= 8'd0;
                        r_addr_q <= r_addr_q + ADDR_ONE;
`ifdef READBACK_CSUM_EN
                        r_state <= S_CSUM;
`else
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_FIN;
`endif
                    end else begin
                        r_rem_q    <= r_rem_q - 8'd1;
                        r_addr_q   <= r_addr_q + ADDR_ONE;
                        r_ram_addr <= r_addr_q + ADDR_ONE;
                        r_ram_re   <= 1'b1;
                        r_state    <= S_FETCH;
                    end
                end
`ifdef READBACK_CSUM_EN
                S_CSUM: begin
                    // Re-reverse so the host decodes the checksum in its own form.
                    r_shift_q    <= bit_rev8(r_csum);
                    r_csum_frame <= 1'b1;
                    r_tx         <= 1'b0;
                    r_baud       <= CNT_ZERO;
                    r_state      <= S_START;
                end
`endif
                S_FIN: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_tx    <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign ram_addr = r_ram_addr;
    assign ram_re   = r_ram_re;
    assign Tx       = r_tx;
    assign busy     = r_busy;
    assign done     = r_done;

endmodule

// File: tb/tb_uart_tx_readback.sv
`timescale 1ns/1ps
module tb_uart_tx_readback;

    localparam int C  = 434;
    localparam int AW = 8;
`ifdef READBACK_CSUM_EN
    localparam int CS = 1;
`else
    localparam int CS = 0;
`endif

    logic          clk_Tx = 1'b0;
    logic          rst_Tx = 1'b1;
    logic          start  = 1'b0;
    logic [AW-1:0] base_addr = 8'h00;
    logic [7:0]    len = 8'h00;
    logic [7:0]    ram_data = 8'h00;
    logic [AW-1:0] ram_addr;
    logic          ram_re;
    logic          Tx;
    logic          busy;
    logic          done;

    uart_tx_readback #(.CLKS_PER_BIT(C), .ADDR_W(AW)) dut (
        .clk_Tx   (clk_Tx),
        .rst_Tx   (rst_Tx),
        .start    (start),
        .base_addr(base_addr),
        .len      (len),
        .ram_addr (ram_addr),
        .ram_re   (ram_re),
        .ram_data (ram_data),
        .Tx       (Tx),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk_Tx = ~clk_Tx;

    int cyc = 0;
    always @(posedge clk_Tx) cyc <= cyc + 1;

    // RAM model with one-cycle read latency
    logic [7:0] mem [256];
    always @(posedge clk_Tx) if (ram_re === 1'b1) ram_data <= mem[ram_addr];

    logic [7:0] rd_log[$];
    always @(negedge clk_Tx) if (ram_re === 1'b1) rd_log.push_back(ram_addr);

    int vectors = 0;
    int miscompares = 0;
    int gen = 0;
    logic [7:0] exp_bytes[$];
    int fall_times[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: decode each Tx frame and compare against the scoreboard queue
    initial begin
        logic [7:0] b;
        logic       sp;
        int         tf;
        int         g;
        forever begin
            @(negedge clk_Tx);
            if (Tx === 1'b0) begin
                tf = cyc;
                g  = gen;
                repeat (C/2) @(negedge clk_Tx);
                for (int i = 0; i < 8; i++) begin
                    repeat (C) @(negedge clk_Tx);
                    b[i] = Tx;
                end
                repeat (C) @(negedge clk_Tx);
                sp = Tx;
                repeat (C - C/2 - 1) @(negedge clk_Tx);
                if (g == gen) begin
                    chk("stop_bit", 32'(sp), 32'h1);
                    if (exp_bytes.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL unexpected_frame: got %0h expected no frame", b);
                    end else begin
                        chk("tx_byte", 32'(b), 32'(exp_bytes.pop_front()));
                    end
                    fall_times.push_back(tf);
                end
            end
        end
    end

    task automatic do_start(input logic [7:0] b, input logic [7:0] l, output int s);
        @(negedge clk_Tx);
        base_addr = b;
        len       = l;
        start     = 1'b1;
        s         = cyc;
        @(negedge clk_Tx);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int dc);
        dc = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk_Tx);
            if (done === 1'b1) begin
                dc = cyc;
                break;
            end
        end
        if (dc < 0) chk("done_timeout", 32'h0, 32'h1);
        else begin
            @(negedge clk_Tx);
            chk("done_width", 32'(done), 32'h0);
        end
    endtask

    task automatic clear_logs();
        rd_log.delete();
        fall_times.delete();
    endtask

    initial begin
        int s;
        int dc;
        int s2;
        logic any_low;

        for (int i = 0; i < 256; i++) mem[i] = 8'h00;

        // Reset and idle
        repeat (5) @(negedge clk_Tx);
        rst_Tx = 1'b0;
        @(negedge clk_Tx);
        chk("rst_tx", 32'(Tx), 32'h1);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_ram_re", 32'(ram_re), 32'h0);
        chk("rst_ram_addr", 32'(ram_addr), 32'h0);
        any_low = 1'b0;
        repeat (1000) begin
            @(negedge clk_Tx);
            if (Tx !== 1'b1) any_low = 1'b1;
        end
        chk("idle_tx_high", 32'(any_low), 32'h0);

        // Single byte: RAM 0x80 -> host 0x01
        clear_logs();
        mem[8'h05] = 8'h80;
        exp_bytes.push_back(8'h01);
`ifdef READBACK_CSUM_EN
        exp_bytes.push_back(8'h01);
`endif
        do_start(8'h05, 8'd1, s);
        chk("single_busy", 32'(busy), 32'h1);
        wait_done((2 + CS) * 10 * C + 100, dc);
        chk("single_rd_count", 32'(rd_log.size()), 32'h1);
        if (rd_log.size() > 0) chk("single_rd_addr", 32'(rd_log[0]), 32'h05);
        chk("single_frames", 32'(fall_times.size()), 32'(1 + CS));
        if (fall_times.size() > 0) begin
            chk("single_latency", 32'(fall_times[0] - s), 32'd3);
            chk("single_done_time", 32'(dc - fall_times[fall_times.size()-1]), 32'(10 * C + 1));
        end
        chk("single_busy_after", 32'(busy), 32'h0);
        chk("single_sb_empty", 32'(exp_bytes.size()), 32'h0);

        // Multi-byte with address wrap
        clear_logs();
        mem[8'hFE] = 8'h55;
        mem[8'hFF] = 8'hAA;
        mem[8'h00] = 8'h0F;
        exp_bytes.push_back(8'hAA);
        exp_bytes.push_back(8'h55);
        exp_bytes.push_back(8'hF0);
`ifdef READBACK_CSUM_EN
        exp_bytes.push_back(8'h0F);
`endif
        do_start(8'hFE, 8'd3, s);
        wait_done((4 + CS) * 10 * C + 100, dc);
        chk("wrap_rd_count", 32'(rd_log.size()), 32'd3);
        if (rd_log.size() == 3) begin
            chk("wrap_rd0", 32'(rd_log[0]), 32'hFE);
            chk("wrap_rd1", 32'(rd_log[1]), 32'hFF);
            chk("wrap_rd2", 32'(rd_log[2]), 32'h00);
        end
        chk("wrap_frames", 32'(fall_times.size()), 32'(3 + CS));
        if (fall_times.size() >= 3) begin
            chk("wrap_gap01", 32'(fall_times[1] - fall_times[0]), 32'(10 * C + 3));
            chk("wrap_gap12", 32'(fall_times[2] - fall_times[1]), 32'(10 * C + 3));
        end
        chk("wrap_sb_empty", 32'(exp_bytes.size()), 32'h0);

        // len = 0, then start held through FIN (ignored) and the next cycle (accepted)
        clear_logs();
        @(negedge clk_Tx);
        base_addr = 8'h10;
        len       = 8'd0;
        start     = 1'b1;
        s         = cyc;
        @(negedge clk_Tx);
        chk("len0_done", 32'(done), 32'h1);
        chk("len0_done_cycle", 32'(cyc - s), 32'd1);
        @(negedge clk_Tx);
        chk("fin_start_ignored", 32'(done), 32'h0);
        @(negedge clk_Tx);
        chk("after_done_start_accepted", 32'(done), 32'h1);
        start = 1'b0;
        any_low = 1'b0;
        repeat (50) begin
            @(negedge clk_Tx);
            if (Tx !== 1'b1) any_low = 1'b1;
        end
        chk("len0_tx_high", 32'(any_low), 32'h0);
        chk("len0_no_read", 32'(rd_log.size()), 32'h0);

        // Start while busy is ignored; also the checksum case (0x12 ^ 0x34 = 0x26)
        clear_logs();
        mem[8'h20] = 8'h48;
        mem[8'h21] = 8'h2C;
        mem[8'h40] = 8'hFF;
        exp_bytes.push_back(8'h12);
        exp_bytes.push_back(8'h34);
`ifdef READBACK_CSUM_EN
        exp_bytes.push_back(8'h26);
`endif
        do_start(8'h20, 8'd2, s);
        repeat (2000) @(negedge clk_Tx);
        do_start(8'h40, 8'd5, s2);
        wait_done((3 + CS) * 10 * C + 100, dc);
        chk("busy_rd_count", 32'(rd_log.size()), 32'd2);
        if (rd_log.size() == 2) begin
            chk("busy_rd0", 32'(rd_log[0]), 32'h20);
            chk("busy_rd1", 32'(rd_log[1]), 32'h21);
        end
        chk("csum_frames", 32'(fall_times.size()), 32'(2 + CS));
        chk("busy_sb_empty", 32'(exp_bytes.size()), 32'h0);
        repeat (20) @(negedge clk_Tx);
        chk("busy_no_extra", 32'(fall_times.size()), 32'(2 + CS));

        // Reset during data bit 4 of byte 2 of 4
        clear_logs();
        mem[8'h30] = 8'h01;
        mem[8'h31] = 8'hC0;
        mem[8'h32] = 8'h3C;
        mem[8'h33] = 8'hE1;
        exp_bytes.push_back(8'h80);
        exp_bytes.push_back(8'h03);
        do_start(8'h30, 8'd4, s);
        for (int i = 0; i < 3 * 10 * C; i++) begin
            if (cyc >= s + 3 + (10 * C + 3) + 5 * C + C / 2) break;
            @(negedge clk_Tx);
        end
        chk("rst_mid_first_frame", 32'(fall_times.size()), 32'h1);
        gen++;
        exp_bytes.delete();
        rst_Tx = 1'b1;
        @(negedge clk_Tx);
        chk("rst_mid_tx", 32'(Tx), 32'h1);
        chk("rst_mid_busy", 32'(busy), 32'h0);
        chk("rst_mid_ram_re", 32'(ram_re), 32'h0);
        rst_Tx = 1'b0;
        any_low = 1'b0;
        repeat (10 * C + 20) begin
            @(negedge clk_Tx);
            if (Tx !== 1'b1) any_low = 1'b1;
        end
        chk("rst_mid_idle_high", 32'(any_low), 32'h0);

        clear_logs();
        exp_bytes.push_back(8'h80);
        exp_bytes.push_back(8'h03);
        exp_bytes.push_back(8'h3C);
        exp_bytes.push_back(8'h87);
`ifdef READBACK_CSUM_EN
        exp_bytes.push_back(8'h38);
`endif
        do_start(8'h30, 8'd4, s);
        wait_done((5 + CS) * 10 * C + 100, dc);
        chk("rerun_rd_count", 32'(rd_log.size()), 32'd4);
        for (int i = 0; i < rd_log.size() && i < 4; i++)
            chk("rerun_rd_addr", 32'(rd_log[i]), 32'(8'h30 + i));
        chk("rerun_frames", 32'(fall_times.size()), 32'(4 + CS));
        if (fall_times.size() > 0)
            chk("rerun_latency", 32'(fall_times[0] - s), 32'd3);
        chk("rerun_sb_empty", 32'(exp_bytes.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Watchdog
    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/uart_tx_readback.md
Name: uart_tx_readback

Overview:
- Serial transmitter for the host link; the outbound counterpart of the UART receiver that loads channel timing bytes into configuration RAM.
- On command, reads a contiguous block of configuration RAM bytes through a 1-cycle-latency read port.
- Sends each byte as 8N1 on Tx, so the host can verify the pulse/delay/type-start settings it wrote.
- Sits beside the receiver at top level and shares the system clock.

Parameters:
- CLKS_PER_BIT, 434, clock cycles per UART bit (50 MHz / 115200 baud); must be ≥ 4.
- ADDR_W, 8, RAM address width.

Ports:
- clk_Tx  in  1  system clock; all logic on posedge.
- rst_Tx  in  1  synchronous reset, active-high.
- start  in  1  one-cycle request to begin a readback block.
- base_addr  in  ADDR_W  first RAM address, sampled when start is accepted.
- len  in  8  number of bytes to send, sampled when start is accepted; 0 means none.
- ram_addr  out  ADDR_W  RAM read address.
- ram_re  out  1  RAM read strobe; data is valid on ram_data one cycle later.
- ram_data  in  8  RAM read data, stored bit-reversed (the receiver's reversed byte).
- Tx  out  1  serial line; idles high.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse when the block completes.

Behaviour:
- Reset: Tx=1, busy=0, done=0, ram_re=0, ram_addr=0, FSM=IDLE, all counters 0. Reset mid-frame aborts the block; Tx is 1 on the first cycle after reset is sampled.
- FSM states: IDLE, FETCH, WAIT, START, DATA, STOP, NEXT, (CSUM), FIN.
- IDLE:
  - When start=1, latch base_addr into addr_q and len into rem_q, and set busy=1.
  - If len=0, go to FIN. Otherwise go to FETCH.
  - start while busy=1 is ignored.
- FETCH: ram_addr=addr_q, ram_re=1 for exactly one cycle, then go to WAIT.
- WAIT: capture ram_data into shift_q on this cycle, then go to START. This accounts for the 1-cycle read latency.
- START: Tx=0 for CLKS_PER_BIT cycles.
- DATA:
  - 8 bits, each held CLKS_PER_BIT cycles.
  - Wire order is shift_q[7], shift_q[6], …, shift_q[0]. This undoes the receiver's bit reversal, so the host receives the byte exactly as it originally sent it (LSB first on the wire).
- STOP: Tx=1 for CLKS_PER_BIT cycles.
- NEXT:
  - Decrement rem_q.
  - Increment addr_q modulo 2^ADDR_W; address FF wraps to 00.
  - If rem_q was 1, go to CSUM (when the optional feature is enabled) or FIN. Otherwise go to FETCH.
- FIN: done=1 for one cycle, busy=0, then go to IDLE. A start in the FIN cycle is ignored. A start on the cycle after done is accepted.
- Timing:
  - Latency from the start cycle to the Tx falling edge is 3 cycles (IDLE→FETCH→WAIT→START).
  - Inter-byte gap after the stop bit is 3 cycles (NEXT, FETCH, WAIT), with Tx held at 1.
  - Frame length is exactly 10·CLKS_PER_BIT cycles.
- Tx is registered (glitch-free). The baud counter is a full-width counter that resets at each bit boundary.
- ram_addr holds its last value when not reading.

Optional Feature:
- Macro: READBACK_CSUM_EN.
- Defined:
  - An 8-bit checksum register is cleared on start acceptance.
  - Each transmitted data byte is XORed into it, in its wire-order (un-reversed) form.
  - After the last data byte, CSUM state sends one extra 8N1 frame carrying the checksum, then goes to FIN.
  - When len=0, no checksum is sent.
- Undefined: the CSUM state and checksum register are absent; NEXT goes directly to FIN.

Test Plan:
- Reset idle: hold rst_Tx 5 cycles, then release -> Tx=1, busy=0, done=0, ram_re=0; after 1000 idle cycles Tx is still 1.
- Single byte:
  - Stimulus: base_addr=0x05, len=1, RAM[5]=0x80 (host byte 0x01 reversed).
  - Required: ram_re high for exactly 1 cycle with ram_addr=0x05; Tx falls 3 cycles after start.
  - Decoded wire byte = 0x01, frame = 4340 cycles; done pulses one cycle after the stop bit.
- Multi-byte wrap:
  - Stimulus: base_addr=0xFE, len=3, RAM[FE,FF,00]=0x55,0xAA,0x0F.
  - Required: read addresses FE, FF, 00 in order; host decodes 0xAA, 0x55, 0xF0; 3-cycle Tx-high gap between frames.
- len=0 and busy-start:
  - len=0 -> no ram_re, Tx stays 1, done pulses at start+1 cycle.
  - start asserted mid-frame with another base_addr -> ignored; the original sequence completes unchanged.
- Reset mid-operation: rst_Tx during DATA bit 4 of byte 2 of 4 -> Tx=1 the next cycle, busy=0; a new start then sends a correct full block.
- Checksum (READBACK_CSUM_EN defined): len=2, host bytes 0x12, 0x34 -> third frame carries 0x26, then done; undefined -> only 2 frames.
